// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: PC register, 2-entry fetch queue, valid/ready hand-off to decode.
// Optional IF_PERF_CNT_EN adds saturating fetched/flushed event counters.
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);

    localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;

    logic [31:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  vld_q, vld_d;
    logic [31:0] ent_pc_q [2];
    logic [31:0] ent_pc_d [2];
    logic [31:0] ent_instr_q [2];
    logic [31:0] ent_instr_d [2];
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        err_q, err_d;

    logic        pop;
    logic        push;
    logic        in_range;
    logic [31:0] word;

    always_comb begin
        in_range    = ({1'b0, pc_q} < IMEM_BYTES);
        word        = in_range ? imem_data : 32'h0;
        pop         = id_valid & id_ready;
        push        = !redirect & ((count_q != 2'd2) | pop);

        pc_d        = pc_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        vld_d       = vld_q;
        ent_pc_d    = ent_pc_q;
        ent_instr_d = ent_instr_q;
        err_d       = err_q;
        id_pc_d     = id_pc_q;
        id_instr_d  = id_instr_q;

        if (redirect) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            count_d  = 2'd0;
            vld_d    = 2'b00;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            // When full, rd_ptr == wr_ptr: the pop frees the slot the push then fills.
            if (pop) begin
                vld_d[rd_ptr_q] = 1'b0;
                rd_ptr_d        = ~rd_ptr_q;
            end
            if (push) begin
                vld_d[wr_ptr_q]       = 1'b1;
                ent_pc_d[wr_ptr_q]    = pc_q;
                ent_instr_d[wr_ptr_q] = word;
                wr_ptr_d              = ~wr_ptr_q;
                pc_d                  = pc_q + 32'd4;
                if (!in_range) begin
                    err_d = 1'b1;
                end
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end

        // Head outputs are registered copies of the next head; they hold while empty.
        if (vld_d[rd_ptr_d]) begin
            id_pc_d    = ent_pc_d[rd_ptr_d];
            id_instr_d = ent_instr_d[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            vld_q      <= 2'b00;
            err_q      <= 1'b0;
            id_pc_q    <= 32'h0;
            id_instr_q <= 32'h0;
        end else begin
            pc_q       <= pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            vld_q      <= vld_d;
            err_q      <= err_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
        end
    end

    always_ff @(posedge clk) begin
        ent_pc_q    <= ent_pc_d;
        ent_instr_q <= ent_instr_d;
    end

    assign imem_addr = pc_q;
    assign id_valid  = vld_q[rd_ptr_q];
    assign id_pc     = id_pc_q;
    assign id_instr  = id_instr_q;
    assign fetch_err = err_q;

`ifdef IF_PERF_CNT_EN
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
        logic [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    logic [31:0] fetched_q, fetched_d;
    logic [31:0] flushed_q, flushed_d;

    // An entry popped in the redirect cycle was accepted by decode, so it is not a flush.
    always_comb begin
        fetched_d = pop ? sat_add(fetched_q, 2'd1) : fetched_q;
        flushed_d = redirect ? sat_add(flushed_q, count_q - {1'b0, pop}) : flushed_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetched_q <= 32'h0;
            flushed_q <= 32'h0;
        end else begin
            fetched_q <= fetched_d;
            flushed_q <= flushed_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue against a queue-based reference model.
`timescale 1ns/1ps
module tb_if_fetch_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] imem_addr, imem_data, id_instr, id_pc, redirect_pc;
    logic        id_valid, id_ready, redirect, fetch_err;

    logic [31:0] imem_addr2, imem_data2, id_instr2, id_pc2;
    logic        id_valid2, fetch_err2;
    logic        id_ready2 = 1'b1;
    logic        redirect2 = 1'b0;
    logic [31:0] redirect_pc2 = 32'h0;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_flushed, perf_fetched2, perf_flushed2;
`endif

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a[31:2] == 30'd1) return 32'h8001_060A;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
    endfunction

    assign imem_data  = mem_fn(imem_addr);
    assign imem_data2 = mem_fn(imem_addr2);

    if_fetch_queue #(.RESET_PC(32'h0), .IMEM_WORDS(128)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .redirect(redirect), .redirect_pc(redirect_pc), .fetch_err(fetch_err)
`ifdef IF_PERF_CNT_EN
        , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
    );

    if_fetch_queue #(.RESET_PC(32'h0000_01FC), .IMEM_WORDS(128)) dut2 (
        .clk(clk), .rst(rst), .imem_addr(imem_addr2), .imem_data(imem_data2),
        .id_valid(id_valid2), .id_ready(id_ready2), .id_instr(id_instr2), .id_pc(id_pc2),
        .redirect(redirect2), .redirect_pc(redirect_pc2), .fetch_err(fetch_err2)
`ifdef IF_PERF_CNT_EN
        , .perf_fetched(perf_fetched2), .perf_flushed(perf_flushed2)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fetch queue as a SystemVerilog queue of {pc, instr}.
    logic [31:0] m_pc;
    logic [63:0] mq[$];
    logic        m_err;
    logic [31:0] m_fetched, m_flushed;

    function automatic logic [31:0] msat(input logic [31:0] a, input int b);
        logic [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    task automatic model_reset();
        m_pc = 32'h0;
        mq.delete();
        m_err = 1'b0;
        m_fetched = 32'h0;
        m_flushed = 32'h0;
    endtask

    task automatic model_edge();
        int n;
        bit p;
        logic [31:0] w;
        n = mq.size();
        p = (n > 0) && id_ready;
        if (redirect) begin
            if (p) m_fetched = msat(m_fetched, 1);
            m_flushed = msat(m_flushed, n - int'(p));
            mq.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (p) m_fetched = msat(m_fetched, 1);
            if (p) void'(mq.pop_front());
            if (n < 2 || p) begin
                if (m_pc < 32'd512) w = mem_fn(m_pc);
                else begin
                    w = 32'h0;
                    m_err = 1'b1;
                end
                mq.push_back({m_pc, w});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic check_model();
        chk("id_valid", 32'(id_valid), 32'(mq.size() > 0));
        chk("imem_addr", imem_addr, m_pc);
        chk("fetch_err", 32'(fetch_err), 32'(m_err));
        if (mq.size() > 0) begin
            chk("id_pc", id_pc, mq[0][63:32]);
            chk("id_instr", id_instr, mq[0][31:0]);
        end
`ifdef IF_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_flushed", perf_flushed, m_flushed);
`endif
    endtask

    task automatic cycle();
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        id_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_id_valid", 32'(id_valid), 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_fetch_err", 32'(fetch_err), 32'h0);
        chk("rst_imem_addr2", imem_addr2, 32'h0000_01FC);

        @(posedge clk);
        #1;
        rst = 1'b0;
        id_ready = 1'b1;

        cycle();
        chk("first_valid", 32'(id_valid), 32'h1);
        chk("first_pc", id_pc, 32'h0);
        chk("edge_pc2", id_pc2, 32'h0000_01FC);
        chk("edge_instr2", id_instr2, mem_fn(32'h0000_01FC));
        chk("edge_err2_clear", 32'(fetch_err2), 32'h0);
        cycle();
        chk("second_pc", id_pc, 32'h4);
        chk("second_instr", id_instr, 32'h8001_060A);
        chk("oor_pc2", id_pc2, 32'h0000_0200);
        chk("oor_instr2", id_instr2, 32'h0);
        chk("oor_err2", 32'(fetch_err2), 32'h1);
        cycle();
        chk("third_pc", id_pc, 32'h8);

        // Stall decode: queue fills with heads 8 and C, PC freezes at 0x10.
        id_ready = 1'b0;
        repeat (5) cycle();
        chk("stall_addr", imem_addr, 32'h10);
        chk("stall_head", id_pc, 32'h8);
        id_ready = 1'b1;
        cycle();
        chk("drain_pc_c", id_pc, 32'hC);
        cycle();
        chk("drain_pc_10", id_pc, 32'h10);

        id_ready = 1'b0;
        cycle();
        cycle();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0133;
        cycle();
        redirect = 1'b0;
        chk("redir_valid", 32'(id_valid), 32'h0);
        chk("redir_addr", imem_addr, 32'h130);
`ifdef IF_PERF_CNT_EN
        chk("redir_flushed", perf_flushed, 32'd2);
`endif
        cycle();
        chk("redir_head", id_pc, 32'h130);

        id_ready = 1'b1;
        cycle();
        redirect = 1'b1;
        redirect_pc = 32'h40;
        cycle();
        redirect = 1'b0;
        cycle();
        chk("redir_pop_head", id_pc, 32'h40);

        redirect = 1'b1;
        redirect_pc = 32'h80;
        cycle();
        redirect_pc = 32'h90;
        cycle();
        redirect = 1'b0;
        cycle();
        chk("b2b_redir_head", id_pc, 32'h90);

        repeat (800) begin
            id_ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0: redirect_pc = 32'($urandom_range(0, 511));
                1: redirect_pc = 32'h1E0 + 32'($urandom_range(0, 64));
                2: redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: redirect_pc = $urandom;
            endcase
            cycle();
        end
        chk("sticky_err2", 32'(fetch_err2), 32'h1);

        redirect = 1'b1;
        redirect_pc = 32'h1F8;
        id_ready = 1'b1;
        cycle();
        redirect = 1'b0;
        repeat (4) cycle();
        id_ready = 1'b0;
        repeat (3) cycle();
        chk("pre_rst_err", 32'(fetch_err), 32'h1);
        chk("pre_rst_valid", 32'(id_valid), 32'h1);

        // Asynchronous reset in the middle of a cycle, no clock edge involved.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(id_valid), 32'h0);
        chk("arst_err", 32'(fetch_err), 32'h0);
        chk("arst_addr", imem_addr, 32'h0);
`ifdef IF_PERF_CNT_EN
        chk("arst_fetched", perf_fetched, 32'h0);
        chk("arst_flushed", perf_flushed, 32'h0);
`endif
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        id_ready = 1'b1;
        repeat (6) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
